pattern_player: RTL and testbench

- Output-side counterpart of the input sampler: drives a stored pattern onto output pins instead of capturing them.
- Host loads up to DEPTH words through a simple write port.
- On start, the block replays words 0..length on out_data, one word per (div+1) clk cycles, either one-shot or looping.
- Sits between the host/config interface and the tile's output pads; used for stimulus generation and loopback self-test of the analyzer.

---
 rtl/la_pkg.sv | 13 +
 rtl/pattern_player_if.sv | 34 +++
 rtl/pattern_player_tick_divider.sv | 36 +++
 rtl/pattern_player.sv | 118 +++++++++++
 tb/tb_pattern_player.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: default geometry and the pattern player FSM state.
package la_pkg;

   localparam int unsigned LaWidth = 8;
   localparam int unsigned LaDepth = 16;
   localparam int unsigned LaDivW  = 8;

   typedef enum logic {
      StIdle = 1'b0,
      StPlay = 1'b1
   } state_e;

endpackage

// File: rtl/pattern_player_if.sv
// Host/config and pad-side signal bundle of the pattern player.
interface pattern_player_if
   import la_pkg::*;
#(
   parameter int unsigned WIDTH = LaWidth,
   parameter int unsigned DEPTH = LaDepth,
   parameter int unsigned DIV_W = LaDivW
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [AW-1:0]    length;
   logic [DIV_W-1:0] div;
   logic             loop;
   logic             start;
   logic             stop;
   logic [WIDTH-1:0] out_data;
   logic             out_strobe;
   logic             busy;
   logic             done;

   modport master (
      output wr_en, wr_addr, wr_data, length, div, loop, start, stop,
      input  out_data, out_strobe, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, length, div, loop, start, stop,
      output out_data, out_strobe, busy, done
   );

endinterface

// File: rtl/pattern_player_tick_divider.sv
// Loadable down-counter; tick_o flags the last cycle of a sample period (count == 0).
module tick_divider
   import la_pkg::*;
#(
   parameter int unsigned DIV_W = LaDivW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [DIV_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             tick_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/pattern_player.sv
// Replays a host-loaded pattern onto output pins, one word per (div+1) cycles, one-shot or looping.
// Define PLAYER_IDLE_ZERO_EN to drive out_data to 0 when playback ends or is stopped.
module pattern_player
   import la_pkg::*;
#(
   parameter int unsigned WIDTH = LaWidth,
   parameter int unsigned DEPTH = LaDepth,
   parameter int unsigned DIV_W = LaDivW
) (
   input logic            clk,
   input logic            rst_n,
   pattern_player_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);

   state_e           state_q;
   logic [AW-1:0]    idx_q;
   logic [AW-1:0]    len_q;
   logic [DIV_W-1:0] div_q;
   logic             loop_q;
   logic [WIDTH-1:0] out_q;
   logic             strobe_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic          start_ok;
   logic          tick;
   logic          cnt_load;
   logic [AW-1:0] idx_nxt;

   assign start_ok = (state_q == StIdle) && bus.start && !bus.stop;
   assign idx_nxt  = idx_q + 1'b1;
   // Reloading on the final tick too is harmless: the counter is ignored in IDLE.
   assign cnt_load = start_ok || ((state_q == StPlay) && !bus.stop && tick);

   tick_divider #(
      .DIV_W(DIV_W)
   ) u_tick_divider (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (cnt_load),
      .load_val_i(start_ok ? bus.div : div_q),
      .en_i      (state_q == StPlay),
      .tick_o    (tick)
   );

   always_ff @(posedge clk) begin
      if (bus.wr_en && !busy_q) begin
         mem_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         len_q    <= '0;
         div_q    <= '0;
         loop_q   <= 1'b0;
         out_q    <= '0;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start_ok) begin
                  state_q  <= StPlay;
                  idx_q    <= '0;
                  len_q    <= bus.length;
                  div_q    <= bus.div;
                  loop_q   <= bus.loop;
                  out_q    <= mem_q[0];
                  strobe_q <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            StPlay: begin
               if (bus.stop) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
`ifdef PLAYER_IDLE_ZERO_EN
                  out_q   <= '0;
`endif
               end else if (tick) begin
                  if (idx_q != len_q) begin
                     idx_q    <= idx_nxt;
                     out_q    <= mem_q[idx_nxt];
                     strobe_q <= 1'b1;
                  end else if (loop_q) begin
                     idx_q    <= '0;
                     out_q    <= mem_q[0];
                     strobe_q <= 1'b1;
                  end else begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
`ifdef PLAYER_IDLE_ZERO_EN
                     out_q   <= '0;
`endif
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.out_data   = out_q;
   assign bus.out_strobe = strobe_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_pattern_player.sv
// Self-checking bench for pattern_player: directed scenarios plus random traffic against a timing model.
module tb_pattern_player;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned DIV_W = 8;
   localparam int unsigned AW    = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pattern_player_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV_W(DIV_W)) bus ();

   pattern_player #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .DIV_W(DIV_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: output is a function of cycles elapsed since the start edge.
   int             m_busy, m_k, m_len, m_div, m_loop;
   logic [WIDTH-1:0] m_out;
   logic           m_strobe, m_done;
   logic [WIDTH-1:0] m_mem [DEPTH];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("out_data", 32'(bus.out_data), 32'(m_out));
      check("out_strobe", 32'(bus.out_strobe), 32'(m_strobe));
      check("busy", 32'(bus.busy), 32'(m_busy != 0));
      check("done", 32'(bus.done), 32'(m_done));
   endtask

   task automatic model_reset();
      m_busy = 0; m_k = 0; m_len = 0; m_div = 0; m_loop = 0;
      m_out = '0; m_strobe = 1'b0; m_done = 1'b0;
   endtask

   task automatic model_step();
      int period, n;
      m_strobe = 1'b0;
      m_done   = 1'b0;
      if (m_busy != 0) begin
         if (bus.stop) begin
            m_busy = 0;
`ifdef PLAYER_IDLE_ZERO_EN
            m_out = '0;
`endif
         end else begin
            m_k++;
            period = m_div + 1;
            n = m_k / period;
            if (m_k % period == 0) begin
               if (m_loop == 0 && n > m_len) begin
                  m_busy = 0;
                  m_done = 1'b1;
`ifdef PLAYER_IDLE_ZERO_EN
                  m_out = '0;
`endif
               end else begin
                  m_out = m_mem[(m_loop != 0) ? n % (m_len + 1) : n];
                  m_strobe = 1'b1;
               end
            end
         end
      end else begin
         if (bus.start && !bus.stop) begin
            m_busy = 1; m_k = 0;
            m_len = int'(bus.length); m_div = int'(bus.div); m_loop = int'(bus.loop);
            m_out = m_mem[0];
            m_strobe = 1'b1;
         end
         if (bus.wr_en) m_mem[bus.wr_addr] = bus.wr_data;
      end
   endtask

   task automatic step();
      model_step();
      @(negedge clk);
      compare_all();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.wr_en = 1'b0;
   endtask

   task automatic write_word(input int addr, input logic [WIDTH-1:0] data);
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(addr);
      bus.wr_data = data;
      step();
   endtask

   task automatic play(input int len, input int dv, input bit lp);
      bus.length = AW'(len);
      bus.div    = DIV_W'(dv);
      bus.loop   = lp;
      bus.start  = 1'b1;
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.length = '0; bus.div = '0; bus.loop = 1'b0;
      bus.start = 1'b0; bus.stop = 1'b0;
      model_reset();
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;

      for (int i = 0; i < int'(DEPTH); i++) write_word(i, WIDTH'($urandom));

      // One-shot, div=0
      write_word(0, 8'h11); write_word(1, 8'h22); write_word(2, 8'h33); write_word(3, 8'h44);
      play(3, 0, 1'b0);
      repeat (8) step();

      // Looping with div=2, then stop mid-word
      play(3, 2, 1'b1);
      repeat (19) step();
      bus.stop = 1'b1;
      step();
      repeat (3) step();

      // length=0 single word
      write_word(0, 8'hA5);
      play(0, 0, 1'b0);
      repeat (4) step();

      // Writes and re-start while busy are ignored; config changes do not matter
      write_word(0, 8'h11);
      play(3, 1, 1'b0);
      bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_data = 8'hFF; bus.start = 1'b1;
      bus.length = 4'd0; bus.div = 8'd5;
      step();
      repeat (10) step();
      play(3, 0, 1'b0);
      repeat (6) step();

      // Asynchronous reset mid-playback
      play(DEPTH - 1, 1, 1'b1);
      repeat (5) step();
      #2 rst_n = 1'b0;
      #1 model_reset();
      compare_all();
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;
      play(2, 0, 1'b0);
      repeat (4) step();

      // start and stop together in IDLE
      bus.start = 1'b1; bus.stop = 1'b1;
      step();
      repeat (2) step();

      // Full-depth wrap
      play(DEPTH - 1, 0, 1'b1);
      repeat (40) step();
      bus.stop = 1'b1;
      step();

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         bus.wr_en   = ($urandom_range(3) == 0);
         bus.wr_addr = AW'($urandom);
         bus.wr_data = WIDTH'($urandom);
         bus.length  = AW'($urandom);
         bus.div     = DIV_W'($urandom_range(3));
         bus.loop    = ($urandom_range(3) == 0);
         bus.start   = ($urandom_range(9) == 0);
         bus.stop    = ($urandom_range(39) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
